icache_ctrl: RTL and testbench



---
 rtl/icache_if.sv | 22 ++
 rtl/icache_ctrl.sv | 103 ++++++++++
 tb/tb_icache_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The cache uses the slave modport; the fetch stage / memory model uses master.
interface icache_if;
   logic [15:0] i_addr;
   logic [15:0] instr;
   logic        i_hit;
   logic        flush;
   logic        mem_re;
   logic [15:0] mem_addr;
   logic        mem_rdy;
   logic [63:0] mem_rd_data;

   modport master (
      output i_addr, flush, mem_rdy, mem_rd_data,
      input  instr, i_hit, mem_re, mem_addr
   );

   modport slave (
      input  i_addr, flush, mem_rdy, mem_rd_data,
      output instr, i_hit, mem_re, mem_addr
   );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: combinational hits, one full-line
// fill per miss, flush invalidates everything (a fill in flight lands invalid).
module icache_ctrl #(
   parameter int INDEX_BITS = 6
) (
   input logic     clk,
   input logic     rst,
   icache_if.slave bus
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 16 - INDEX_BITS - 2;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                state;
   logic [LINES-1:0]      valid;
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [63:0]           data_mem [LINES];
   logic                  drop;
   logic                  mem_re_q;
   logic [15:0]           mem_addr_q;

   logic [1:0]            off;
   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic [INDEX_BITS-1:0] fill_idx;
   logic [TAG_BITS-1:0]   fill_tag;
   logic                  hit;
   logic [63:0]           line;
   logic [15:0]           word;

   assign off      = bus.i_addr[1:0];
   assign idx      = bus.i_addr[INDEX_BITS+1:2];
   assign tag      = bus.i_addr[15:INDEX_BITS+2];
   assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
   assign fill_tag = mem_addr_q[15:INDEX_BITS+2];

   // Lookups are only honoured in IDLE so a half-filled line is never served.
   assign hit = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag);

   always_comb begin
      line = data_mem[idx];
      word = '0;
      case (off)
         2'd0: word = line[15:0];
         2'd1: word = line[31:16];
         2'd2: word = line[47:32];
         2'd3: word = line[63:48];
         default: word = '0;
      endcase
   end

   assign bus.i_hit    = hit;
   assign bus.instr    = hit ? word : 16'h0000;
   assign bus.mem_re   = mem_re_q;
   assign bus.mem_addr = mem_addr_q;

   // Tag and data are written on every completed fill, even a dropped one.
   always_ff @(posedge clk) begin
      if (state == FILL && bus.mem_rdy) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= bus.mem_rd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         valid      <= '0;
         drop       <= 1'b0;
         mem_re_q   <= 1'b0;
         mem_addr_q <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (bus.flush) begin
                  valid <= '0;
               end else if (!hit) begin
                  mem_addr_q <= {bus.i_addr[15:2], 2'b00};
                  mem_re_q   <= 1'b1;
                  state      <= FILL;
               end
            end
            FILL: begin
               if (bus.mem_rdy) begin
                  if (bus.flush) begin
                     valid <= '0;
                  end else if (!drop) begin
                     valid[fill_idx] <= 1'b1;
                  end
                  mem_re_q <= 1'b0;
                  drop     <= 1'b0;
                  state    <= IDLE;
               end else if (bus.flush) begin
                  valid <= '0;
                  drop  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl: cold miss, eviction, flushes,
// spurious mem_rdy, address changes during fill and reset mid-fill.
module tb_icache_ctrl;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   icache_if bus ();

   icache_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic complete_fill(input logic [63:0] data);
      bus.mem_rdy     = 1'b1;
      bus.mem_rd_data = data;
      tick();
      bus.mem_rdy     = 1'b0;
      bus.mem_rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      bus.i_addr      = 16'h0000;
      bus.flush       = 1'b0;
      bus.mem_rdy     = 1'b0;
      bus.mem_rd_data = 64'h0;
      #2;
      vectors++;
      if (bus.i_hit !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_hit: got %b want 0", bus.i_hit);
      end
      vectors++;
      if (bus.instr !== 16'h0000) begin
         miscompares++; $display("[TB] FAIL reset_instr: got %h want 0000", bus.instr);
      end
      vectors++;
      if (bus.mem_re !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_mem_re: got %b want 0", bus.mem_re);
      end
      vectors++;
      if (bus.mem_addr !== 16'h0000) begin
         miscompares++; $display("[TB] FAIL reset_mem_addr: got %h want 0000", bus.mem_addr);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_cold_miss();
      #1;
      vectors++;
      if (bus.i_hit !== 1'b0) begin
         miscompares++; $display("[TB] FAIL cold_miss_hit: got %b want 0", bus.i_hit);
      end
      tick();
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL cold_req: got re=%b addr=%h want re=1 addr=0000", bus.mem_re, bus.mem_addr);
      end
      tick();
      tick();
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.i_hit !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL cold_wait: got re=%b hit=%b want re=1 hit=0", bus.mem_re, bus.i_hit);
      end
      complete_fill(64'h4444_3333_2222_1111);
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'h1111) begin
         miscompares++;
         $display("[TB] FAIL cold_hit_w0: got hit=%b instr=%h want hit=1 instr=1111", bus.i_hit, bus.instr);
      end
      bus.i_addr = 16'h0003;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'h4444 || bus.mem_re !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL cold_hit_w3: got hit=%b instr=%h re=%b want hit=1 instr=4444 re=0",
                  bus.i_hit, bus.instr, bus.mem_re);
      end
   endtask

   task automatic test_conflict();
      bus.i_addr = 16'h0104;
      tick();
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0104) begin
         miscompares++;
         $display("[TB] FAIL conf_req_a: got re=%b addr=%h want re=1 addr=0104", bus.mem_re, bus.mem_addr);
      end
      complete_fill(64'hA003_A002_A001_A000);
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'hA000) begin
         miscompares++;
         $display("[TB] FAIL conf_hit_a: got hit=%b instr=%h want hit=1 instr=A000", bus.i_hit, bus.instr);
      end
      bus.i_addr = 16'h0204;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b0) begin
         miscompares++; $display("[TB] FAIL conf_miss_b: got hit=%b want 0", bus.i_hit);
      end
      tick();
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0204) begin
         miscompares++;
         $display("[TB] FAIL conf_req_b: got re=%b addr=%h want re=1 addr=0204", bus.mem_re, bus.mem_addr);
      end
      complete_fill(64'hB003_B002_B001_B000);
      bus.i_addr = 16'h0206;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'hB002) begin
         miscompares++;
         $display("[TB] FAIL conf_hit_b: got hit=%b instr=%h want hit=1 instr=B002", bus.i_hit, bus.instr);
      end
      bus.i_addr = 16'h0001;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'h2222) begin
         miscompares++;
         $display("[TB] FAIL conf_other_line: got hit=%b instr=%h want hit=1 instr=2222", bus.i_hit, bus.instr);
      end
      bus.i_addr = 16'h0104;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b0) begin
         miscompares++; $display("[TB] FAIL conf_evicted: got hit=%b want 0", bus.i_hit);
      end
      tick();
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0104) begin
         miscompares++;
         $display("[TB] FAIL conf_refetch: got re=%b addr=%h want re=1 addr=0104", bus.mem_re, bus.mem_addr);
      end
      complete_fill(64'hA003_A002_A001_A000);
   endtask

   task automatic test_flush_idle();
      bus.i_addr = 16'h0000;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b1) begin
         miscompares++; $display("[TB] FAIL flush_pre_hit: got %b want 1", bus.i_hit);
      end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b0 || bus.mem_re !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_idle_after: got hit=%b re=%b want hit=0 re=0", bus.i_hit, bus.mem_re);
      end
      tick();
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL flush_idle_req: got re=%b addr=%h want re=1 addr=0000", bus.mem_re, bus.mem_addr);
      end
      complete_fill(64'h4444_3333_2222_1111);
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'h1111) begin
         miscompares++;
         $display("[TB] FAIL flush_idle_refill: got hit=%b instr=%h want hit=1 instr=1111", bus.i_hit, bus.instr);
      end
   endtask

   task automatic test_flush_fill();
      bus.i_addr = 16'h0008;
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tick();
      complete_fill(64'hC003_C002_C001_C000);
      vectors++;
      if (bus.i_hit !== 1'b0 || bus.mem_re !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_fill_drop: got hit=%b re=%b want hit=0 re=0", bus.i_hit, bus.mem_re);
      end
      tick();
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0008) begin
         miscompares++;
         $display("[TB] FAIL flush_fill_req: got re=%b addr=%h want re=1 addr=0008", bus.mem_re, bus.mem_addr);
      end
      complete_fill(64'hC003_C002_C001_C000);
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'hC000) begin
         miscompares++;
         $display("[TB] FAIL flush_fill_hit: got hit=%b instr=%h want hit=1 instr=C000", bus.i_hit, bus.instr);
      end
      bus.i_addr = 16'h0000;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b0) begin
         miscompares++; $display("[TB] FAIL flush_fill_all: got hit=%b want 0", bus.i_hit);
      end
      bus.i_addr = 16'h000C;
      tick();
      bus.flush = 1'b1;
      complete_fill(64'hD003_D002_D001_D000);
      bus.flush = 1'b0;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b0 || bus.mem_re !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_same_drop: got hit=%b re=%b want hit=0 re=0", bus.i_hit, bus.mem_re);
      end
      tick();
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h000C) begin
         miscompares++;
         $display("[TB] FAIL flush_same_req: got re=%b addr=%h want re=1 addr=000C", bus.mem_re, bus.mem_addr);
      end
      complete_fill(64'hD003_D002_D001_D000);
   endtask

   task automatic test_spurious();
      bus.i_addr = 16'h000D;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'hD001) begin
         miscompares++;
         $display("[TB] FAIL spur_pre: got hit=%b instr=%h want hit=1 instr=D001", bus.i_hit, bus.instr);
      end
      complete_fill(64'h9999_8888_7777_6666);
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'hD001 || bus.mem_re !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL spur_post: got hit=%b instr=%h re=%b want hit=1 instr=D001 re=0",
                  bus.i_hit, bus.instr, bus.mem_re);
      end
      bus.i_addr = 16'h0300;
      tick();
      bus.i_addr = 16'h0444;
      tick();
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0300) begin
         miscompares++;
         $display("[TB] FAIL addr_change: got re=%b addr=%h want re=1 addr=0300", bus.mem_re, bus.mem_addr);
      end
      complete_fill(64'hE003_E002_E001_E000);
      vectors++;
      if (bus.i_hit !== 1'b0) begin
         miscompares++; $display("[TB] FAIL addr_change_miss: got hit=%b want 0", bus.i_hit);
      end
      bus.i_addr = 16'h0300;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'hE000) begin
         miscompares++;
         $display("[TB] FAIL addr_change_hit: got hit=%b instr=%h want hit=1 instr=E000", bus.i_hit, bus.instr);
      end
   endtask

   task automatic test_reset_mid_fill();
      bus.i_addr = 16'h0500;
      tick();
      #2;
      rst        = 1'b1;
      bus.i_addr = 16'h0300;
      #1;
      vectors++;
      if (bus.mem_re !== 1'b0 || bus.i_hit !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rst_mid: got re=%b hit=%b want re=0 hit=0", bus.mem_re, bus.i_hit);
      end
      @(posedge clk);
      #1;
      rst        = 1'b0;
      bus.i_addr = 16'h0500;
      complete_fill(64'hF003_F002_F001_F000);
      vectors++;
      if (bus.i_hit !== 1'b0 || bus.mem_re !== 1'b1 || bus.mem_addr !== 16'h0500) begin
         miscompares++;
         $display("[TB] FAIL rst_late_rdy: got hit=%b re=%b addr=%h want hit=0 re=1 addr=0500",
                  bus.i_hit, bus.mem_re, bus.mem_addr);
      end
      complete_fill(64'h5003_5002_5001_5000);
      bus.i_addr = 16'h0501;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b1 || bus.instr !== 16'h5001) begin
         miscompares++;
         $display("[TB] FAIL rst_refill: got hit=%b instr=%h want hit=1 instr=5001", bus.i_hit, bus.instr);
      end
      bus.i_addr = 16'h0300;
      #1;
      vectors++;
      if (bus.i_hit !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rst_invalidated: got hit=%b want 0", bus.i_hit);
      end
   endtask

   // Guard against a stalled run so the bench always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_cold_miss();
      test_conflict();
      test_flush_idle();
      test_flush_fill();
      test_spurious();
      test_reset_mid_fill();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
